sync_fifo_prog: RTL and testbench

- Parametrised single-clock synchronous FIFO; next generation of the team's FIFO.
- Adds the following over the previous FIFO:
  - non-power-of-two depth with explicit pointer wrap
  - selectable standard or first-word-fall-through (FWFT) read mode
  - runtime-programmable almost-full / almost-empty thresholds
  - occupancy output
  - sticky error flags with clear
- Sits between producer and consumer stages anywhere in the datapath.

---
 rtl/sync_fifo_prog_if.sv | 45 ++++
 rtl/sync_fifo_prog.sv | 138 +++++++++++++
 tb/tb_sync_fifo_prog.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_prog_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_prog_if
// Description : Handshake, data and status bundle for sync_fifo_prog.
//               The master side is the producer/consumer; the slave side is
//               the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_prog_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AW         = $clog2(FIFO_DEPTH)
) ();
    logic                  wr_en;
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  valid;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic [AW:0]           count;
    logic [AW:0]           af_thresh;
    logic [AW:0]           ae_thresh;
    logic                  err_clr;
    logic                  ovf_sticky;
    logic                  udf_sticky;

    modport master (
        output wr_en, data_in, rd_en, af_thresh, ae_thresh, err_clr,
        input  data_out, valid, wr_ack, overflow, underflow, full, empty,
               almostfull, almostempty, count, ovf_sticky, udf_sticky
    );

    modport slave (
        input  wr_en, data_in, rd_en, af_thresh, ae_thresh, err_clr,
        output data_out, valid, wr_ack, overflow, underflow, full, empty,
               almostfull, almostempty, count, ovf_sticky, udf_sticky
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_prog
// Description : Single-clock FIFO with arbitrary depth, standard or
//               first-word-fall-through read, programmable almost-full /
//               almost-empty thresholds, occupancy and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_prog #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int FWFT       = 0,
    parameter int AW         = $clog2(FIFO_DEPTH)
) (
    input  wire logic           clk,
    input  wire logic           rst,
    sync_fifo_prog_if.slave     fifo_if
);

    // Depth need not be a power of two, so pointers wrap on this value.
    localparam logic [AW-1:0] c_LAST_PTR  = AW'(FIFO_DEPTH - 1);
    localparam logic [AW-1:0] c_PTR_ONE   = AW'(1);
    localparam logic [AW:0]   c_DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   c_CNT_ONE   = (AW+1)'(1);

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  r_ovf_sticky;
    logic                  r_udf_sticky;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_ovf_evt;
    logic                  w_udf_evt;

    // Flags come straight from the occupancy so accept decisions see this
    // cycle's state; a full FIFO never takes a write even alongside a read.
    assign w_full    = (r_count == c_DEPTH_CNT);
    assign w_empty   = (r_count == '0);
    assign w_wr_acc  = fifo_if.wr_en & ~w_full;
    assign w_rd_acc  = fifo_if.rd_en & ~w_empty;
    assign w_ovf_evt = fifo_if.wr_en & w_full;
    assign w_udf_evt = fifo_if.rd_en & w_empty;

    // Storage array; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= fifo_if.data_in;
        end
    end

    // Write/read pointers with explicit wrap, plus the occupancy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PTR_ONE;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // One-cycle status pulses and sticky error flags (a new event beats clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ack     <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_udf_sticky <= 1'b0;
        end else begin
            r_wr_ack     <= w_wr_acc;
            r_overflow   <= w_ovf_evt;
            r_underflow  <= w_udf_evt;
            r_ovf_sticky <= w_ovf_evt | (r_ovf_sticky & ~fifo_if.err_clr);
            r_udf_sticky <= w_udf_evt | (r_udf_sticky & ~fifo_if.err_clr);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft_read
            // Head of queue is always presented; valid simply mirrors !empty.
            assign fifo_if.data_out = r_mem[r_rd_ptr];
            assign fifo_if.valid    = ~w_empty;
        end else begin : g_std_read
            logic [FIFO_WIDTH-1:0] r_data_out;
            logic                  r_valid;

            // Registered read: data lands one cycle after an accepted read.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data_out <= '0;
                    r_valid    <= 1'b0;
                end else begin
                    r_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_data_out <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign fifo_if.data_out = r_data_out;
            assign fifo_if.valid    = r_valid;
        end
    endgenerate

    // Thresholds are used live; af_thresh=0 and ae_thresh>=depth fall out
    // of the comparisons naturally since count is bounded by the depth.
    assign fifo_if.full        = w_full;
    assign fifo_if.empty       = w_empty;
    assign fifo_if.almostfull  = (r_count >= fifo_if.af_thresh);
    assign fifo_if.almostempty = (r_count <= fifo_if.ae_thresh);
    assign fifo_if.count       = r_count;
    assign fifo_if.wr_ack      = r_wr_ack;
    assign fifo_if.overflow    = r_overflow;
    assign fifo_if.underflow   = r_underflow;
    assign fifo_if.ovf_sticky  = r_ovf_sticky;
    assign fifo_if.udf_sticky  = r_udf_sticky;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_prog
// Description : Self-checking bench for sync_fifo_prog: depth-8 standard,
//               depth-5 standard and depth-8 FWFT instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_prog;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    sync_fifo_prog_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) if8 ();
    sync_fifo_prog_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) if5 ();
    sync_fifo_prog_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) ifw ();

    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) u_dut8 (
        .clk(clk), .rst(rst), .fifo_if(if8));
    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .FWFT(0)) u_dut5 (
        .clk(clk), .rst(rst), .fifo_if(if5));
    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1)) u_dutw (
        .clk(clk), .rst(rst), .fifo_if(ifw));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags: {full, empty, almostfull, almostempty, wr_ack, overflow,
    //         underflow, valid, ovf_sticky, udf_sticky}
    typedef struct {
        logic        wr;
        logic [15:0] din;
        logic        rd;
        logic [3:0]  af;
        logic [3:0]  ae;
        logic        clr;
        logic [3:0]  cnt;
        logic [9:0]  flg;
        logic [15:0] dout;
    } vec_t;

    vec_t tv [40];

    function automatic vec_t mk(input logic wr, input logic [15:0] din,
                                input logic rd, input logic [3:0] af,
                                input logic [3:0] ae, input logic clr,
                                input logic [3:0] cnt, input logic [9:0] flg,
                                input logic [15:0] dout);
        vec_t v;
        v.wr = wr; v.din = din; v.rd = rd; v.af = af; v.ae = ae; v.clr = clr;
        v.cnt = cnt; v.flg = flg; v.dout = dout;
        return v;
    endfunction

    function automatic logic [9:0] flags8();
        return {if8.full, if8.empty, if8.almostfull, if8.almostempty,
                if8.wr_ack, if8.overflow, if8.underflow, if8.valid,
                if8.ovf_sticky, if8.udf_sticky};
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_q[$];
        logic [15:0] e;
        total = 0;
        bad   = 0;

        // ---------------- vector table for the depth-8 standard FIFO ----
        //               wr din      rd af ae clr cnt flags          dout
        tv[0]  = mk(1, 16'h0001, 0, 6, 2, 0, 1, 10'b0001100000, 16'h0000);
        tv[1]  = mk(1, 16'h0002, 0, 6, 2, 0, 2, 10'b0001100000, 16'h0000);
        tv[2]  = mk(1, 16'h0003, 0, 6, 2, 0, 3, 10'b0000100000, 16'h0000);
        tv[3]  = mk(1, 16'h0004, 0, 6, 2, 0, 4, 10'b0000100000, 16'h0000);
        tv[4]  = mk(0, 16'h0000, 0, 3, 2, 0, 4, 10'b0010000000, 16'h0000);
        tv[5]  = mk(1, 16'h0005, 0, 6, 2, 0, 5, 10'b0000100000, 16'h0000);
        tv[6]  = mk(1, 16'h0006, 0, 6, 2, 0, 6, 10'b0010100000, 16'h0000);
        tv[7]  = mk(1, 16'h0007, 0, 6, 2, 0, 7, 10'b0010100000, 16'h0000);
        tv[8]  = mk(1, 16'h0008, 0, 6, 2, 0, 8, 10'b1010100000, 16'h0000);
        tv[9]  = mk(1, 16'hFFFF, 0, 6, 2, 0, 8, 10'b1010010010, 16'h0000);
        tv[10] = mk(0, 16'h0000, 0, 6, 2, 0, 8, 10'b1010000010, 16'h0000);
        tv[11] = mk(0, 16'h0000, 0, 6, 2, 1, 8, 10'b1010000000, 16'h0000);
        tv[12] = mk(0, 16'h0000, 1, 6, 2, 0, 7, 10'b0010000100, 16'h0001);
        tv[13] = mk(0, 16'h0000, 1, 6, 2, 0, 6, 10'b0010000100, 16'h0002);
        tv[14] = mk(0, 16'h0000, 1, 6, 2, 0, 5, 10'b0000000100, 16'h0003);
        tv[15] = mk(0, 16'h0000, 1, 6, 2, 0, 4, 10'b0000000100, 16'h0004);
        tv[16] = mk(0, 16'h0000, 1, 6, 2, 0, 3, 10'b0000000100, 16'h0005);
        tv[17] = mk(0, 16'h0000, 1, 6, 2, 0, 2, 10'b0001000100, 16'h0006);
        tv[18] = mk(0, 16'h0000, 1, 6, 2, 0, 1, 10'b0001000100, 16'h0007);
        tv[19] = mk(0, 16'h0000, 1, 6, 2, 0, 0, 10'b0101000100, 16'h0008);
        tv[20] = mk(0, 16'h0000, 1, 6, 2, 0, 0, 10'b0101001001, 16'h0008);
        tv[21] = mk(0, 16'h0000, 0, 6, 2, 0, 0, 10'b0101000001, 16'h0008);
        tv[22] = mk(1, 16'h1111, 1, 6, 2, 1, 1, 10'b0001101001, 16'h0008);
        tv[23] = mk(0, 16'h0000, 0, 6, 2, 1, 1, 10'b0001000000, 16'h0008);
        tv[24] = mk(1, 16'h2001, 0, 6, 2, 0, 2, 10'b0001100000, 16'h0008);
        tv[25] = mk(1, 16'h2002, 0, 6, 2, 0, 3, 10'b0000100000, 16'h0008);
        tv[26] = mk(1, 16'h2003, 0, 6, 2, 0, 4, 10'b0000100000, 16'h0008);
        tv[27] = mk(1, 16'h2004, 0, 6, 2, 0, 5, 10'b0000100000, 16'h0008);
        tv[28] = mk(1, 16'h2005, 0, 6, 2, 0, 6, 10'b0010100000, 16'h0008);
        tv[29] = mk(1, 16'h2006, 0, 6, 2, 0, 7, 10'b0010100000, 16'h0008);
        tv[30] = mk(1, 16'h2007, 0, 6, 2, 0, 8, 10'b1010100000, 16'h0008);
        tv[31] = mk(1, 16'h3333, 1, 6, 2, 0, 7, 10'b0010010110, 16'h1111);
        tv[32] = mk(1, 16'h4444, 1, 6, 2, 0, 7, 10'b0010100110, 16'h2001);
        tv[33] = mk(0, 16'h0000, 1, 6, 2, 0, 6, 10'b0010000110, 16'h2002);
        tv[34] = mk(0, 16'h0000, 1, 6, 2, 0, 5, 10'b0000000110, 16'h2003);
        tv[35] = mk(0, 16'h0000, 1, 6, 2, 0, 4, 10'b0000000110, 16'h2004);
        tv[36] = mk(0, 16'h0000, 1, 6, 2, 0, 3, 10'b0000000110, 16'h2005);
        tv[37] = mk(0, 16'h0000, 1, 6, 2, 0, 2, 10'b0001000110, 16'h2006);
        tv[38] = mk(0, 16'h0000, 1, 6, 2, 0, 1, 10'b0001000110, 16'h2007);
        tv[39] = mk(0, 16'h0000, 1, 6, 2, 0, 0, 10'b0101000110, 16'h4444);

        // ---------------- idle inputs and reset ----------------
        if8.wr_en = 0; if8.rd_en = 0; if8.data_in = '0; if8.err_clr = 0;
        if8.af_thresh = 4'd6; if8.ae_thresh = 4'd2;
        if5.wr_en = 0; if5.rd_en = 0; if5.data_in = '0; if5.err_clr = 0;
        if5.af_thresh = 4'd5; if5.ae_thresh = 4'd0;
        ifw.wr_en = 0; ifw.rd_en = 0; ifw.data_in = '0; ifw.err_clr = 0;
        ifw.af_thresh = 4'd8; ifw.ae_thresh = 4'd0;
        rst = 1;
        cyc();
        cyc();
        rst = 0;

        chk("rst_count", 0, 32'(if8.count), 32'd0);
        chk("rst_flags", 0, 32'(flags8()), 32'(10'b0101000000));
        chk("rst_dout", 0, 32'(if8.data_out), 32'h0000);

        // ---------------- table-driven run on depth-8 standard ----------
        for (int i = 0; i < 40; i++) begin
            if8.wr_en     = tv[i].wr;
            if8.data_in   = tv[i].din;
            if8.rd_en     = tv[i].rd;
            if8.af_thresh = tv[i].af;
            if8.ae_thresh = tv[i].ae;
            if8.err_clr   = tv[i].clr;
            cyc();
            chk("tbl_count", i, 32'(if8.count), 32'(tv[i].cnt));
            chk("tbl_flags", i, 32'(flags8()), 32'(tv[i].flg));
            chk("tbl_dout", i, 32'(if8.data_out), 32'(tv[i].dout));
        end
        if8.wr_en = 0; if8.rd_en = 0; if8.err_clr = 0;

        // ---------------- depth-5 wrap with interleaved traffic ----------
        for (int i = 0; i < 2; i++) begin
            if5.wr_en   = 1;
            if5.data_in = 16'h5000 + 16'(i);
            exp_q.push_back(if5.data_in);
            cyc();
        end
        chk("d5_prefill_count", 0, 32'(if5.count), 32'd2);
        for (int i = 0; i < 13; i++) begin
            if5.wr_en   = 1;
            if5.rd_en   = 1;
            if5.data_in = 16'h5002 + 16'(i);
            exp_q.push_back(if5.data_in);
            cyc();
            e = exp_q.pop_front();
            chk("d5_pair_count", i, 32'(if5.count), 32'd2);
            chk("d5_pair_fe", i, {30'd0, if5.full, if5.empty}, 32'd0);
            chk("d5_pair_valid", i, 32'(if5.valid), 32'd1);
            chk("d5_pair_data", i, 32'(if5.data_out), 32'(e));
        end
        if5.wr_en = 0;
        for (int i = 0; i < 2; i++) begin
            if5.rd_en = 1;
            cyc();
            e = exp_q.pop_front();
            chk("d5_drain_data", i, 32'(if5.data_out), 32'(e));
        end
        if5.rd_en = 0;
        chk("d5_drain_empty", 0, 32'(if5.empty), 32'd1);

        // ---------------- FWFT behaviour and mid-operation reset ----------
        chk("fw_init_valid", 0, 32'(ifw.valid), 32'd0);
        ifw.wr_en = 1; ifw.data_in = 16'hABCD;
        cyc();
        ifw.wr_en = 0;
        chk("fw_wr_valid", 0, 32'(ifw.valid), 32'd1);
        chk("fw_wr_data", 0, 32'(ifw.data_out), 32'hABCD);
        cyc();
        chk("fw_hold_valid", 0, 32'(ifw.valid), 32'd1);
        chk("fw_hold_data", 0, 32'(ifw.data_out), 32'hABCD);
        ifw.rd_en = 1;
        cyc();
        chk("fw_pop_valid", 0, 32'(ifw.valid), 32'd0);
        chk("fw_pop_empty", 0, 32'(ifw.empty), 32'd1);
        cyc();
        ifw.rd_en = 0;
        chk("fw_udf", 0, {30'd0, ifw.underflow, ifw.udf_sticky}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            ifw.wr_en = 1; ifw.data_in = 16'h0A01 + 16'(i);
            cyc();
        end
        ifw.wr_en = 0;
        chk("fw_fill_count", 0, 32'(ifw.count), 32'd3);
        chk("fw_fill_head", 0, 32'(ifw.data_out), 32'h0A01);
        ifw.rd_en = 1;
        cyc();
        ifw.rd_en = 0;
        chk("fw_newhead", 0, 32'(ifw.data_out), 32'h0A02);
        chk("fw_newhead_count", 0, 32'(ifw.count), 32'd2);
        ifw.wr_en = 1; ifw.data_in = 16'h0A04;
        cyc();
        ifw.wr_en = 0;
        chk("fw_pre_rst_count", 0, 32'(ifw.count), 32'd3);
        rst = 1;
        cyc();
        rst = 0;
        chk("fw_rst_count", 0, 32'(ifw.count), 32'd0);
        chk("fw_rst_state", 0,
            {28'd0, ifw.empty, ifw.valid, ifw.ovf_sticky, ifw.udf_sticky},
            32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
